bf_stdout_ctrl: RTL and testbench

Sequences the CPU's stdout byte stream onto the shared UART transmitter. Bytes strobed by the brainfuck core (stdout/stdout_en) are buffered in a small FIFO. A launch FSM hands them one at a time to the UART TX using its start/busy handshake. The block back-pressures the core with a stall when the buffer is full and reports when output has fully drained after the program halts.

---
 rtl/bf_pkg.sv | 14 +
 rtl/bf_sync_fifo.sv | 47 ++++
 rtl/bf_stdout_ctrl.sv | 109 ++++++++++
 tb/tb_bf_stdout_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and constants for the brainfuck stdout path.
package bf_pkg;

    localparam int DATA_W         = 8;
    localparam int DEPTH_LOG2_DEF = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/bf_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; reads are combinational from the head entry.
module bf_sync_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic                do_push;
    logic                do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/bf_stdout_ctrl.sv
// Buffers CPU stdout bytes and launches them one at a time onto the UART TX.
//
// state     | meaning
// IDLE      | waiting for a buffered byte and an idle UART
// LAUNCH    | tx_start high for this single cycle
// WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TIMEOUT
// WAIT_DONE | frame in progress, waiting for tx_busy to fall
module bf_stdout_ctrl
    import bf_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int DATA_W       = bf_pkg::DATA_W,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] stdout,
    input  logic              stdout_en,
    input  logic              cpu_halt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              drained,
    output logic [7:0]        overflow_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    // WAIT_BUSY is entered one cycle after tx_start, so it lasts BUSY_TIMEOUT-1 cycles.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT - 2);

    ctrl_state_e         state;
    logic [TMR_W-1:0]    timer;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic [DEPTH_LOG2:0] count_nxt;
    logic                push_ok;
    logic                pop_ok;

    assign push_ok   = stdout_en && !fifo_full;
    assign pop_ok    = (state == IDLE) && !fifo_empty && !tx_busy;
    assign count_nxt = fifo_count + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);

    bf_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stdout_en),
        .wdata (stdout),
        .pop   (pop_ok),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_ok) begin
                        state    <= LAUNCH;
                        tx_data  <= fifo_rdata;
                        tx_start <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                    timer <= TMR_LOAD;
                end
                WAIT_BUSY: begin
                    if (tx_busy)            state <= WAIT_DONE;
                    else if (timer == '0)   state <= IDLE;
                    else                    timer <= timer - 1'b1;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall looks at next-cycle occupancy so the write landing with the stall still fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stall    <= 1'b0;
            drained      <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            cpu_stall <= (count_nxt >= (DEPTH_LOG2+1)'(DEPTH - 1));
            drained   <= cpu_halt && fifo_empty && (state == IDLE) && !stdout_en;
            if (stdout_en && fifo_full && (overflow_cnt != 8'hFF))
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_bf_stdout_ctrl.sv
// Directed and randomized bench for bf_stdout_ctrl with a behavioural UART responder.
module tb_bf_stdout_ctrl;

    localparam int BUSY_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] stdout = '0;
    logic       stdout_en = 1'b0;
    logic       cpu_halt = 1'b0;
    logic       tx_busy = 1'b0;
    logic       cpu_stall;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       drained;
    logic [7:0] overflow_cnt;

    bf_stdout_ctrl #(
        .DEPTH_LOG2   (3),
        .DATA_W       (8),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stdout       (stdout),
        .stdout_en    (stdout_en),
        .cpu_halt     (cpu_halt),
        .cpu_stall    (cpu_stall),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .drained      (drained),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // UART responder: busy rises rise_dly cycles after a tx_start and stays high hold_len cycles.
    int rise_dly = 2;
    int hold_len = 10;
    int wait_cnt = 0;
    int hold_cnt = 0;
    bit force_busy = 1'b0;
    bit uart_silent = 1'b0;

    always @(posedge clk) begin
        if (hold_cnt > 0) hold_cnt--;
        if (tx_start && !uart_silent) wait_cnt = rise_dly;
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) hold_cnt = hold_len;
        end
        tx_busy <= force_busy || (hold_cnt > 0);
    end

    logic [7:0] obs_q[$];
    int         start_q[$];

    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            obs_q.push_back(tx_data);
            start_q.push_back(cyc);
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        stdout    = b;
        stdout_en = 1'b1;
        @(posedge clk);
        #1;
        stdout_en = 1'b0;
    endtask

    task automatic wr_polite(input logic [7:0] b);
        int g;
        @(negedge clk);
        g = 0;
        while (cpu_stall && g < 400) begin
            @(negedge clk);
            g++;
        end
        stdout    = b;
        stdout_en = 1'b1;
        @(posedge clk);
        #1;
        stdout_en = 1'b0;
    endtask

    task automatic wait_frames(input int base, input int n, input int limit);
        int k;
        k = 0;
        while (obs_q.size() < base + n && k < limit) begin
            @(negedge clk);
            k++;
        end
        tick(30);
    endtask

    function automatic int min_gap(input int base);
        int m;
        m = 9999;
        for (int i = base + 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] < m) m = start_q[i] - start_q[i-1];
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         falls;
        bit         early;
        logic       prev_busy;
        int         k;
        logic [7:0] exp_q[$];
        logic [7:0] hello [5];
        logic [7:0] b;

        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F;

        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_drained", 32'(drained), 0);
        chk("rst_overflow", 32'(overflow_cnt), 0);

        // single byte
        base = obs_q.size();
        wr(8'h48);
        wait_frames(base, 1, 100);
        chk("single_count", 32'(obs_q.size() - base), 1);
        if (obs_q.size() > base) chk("single_data", 32'(obs_q[base]), 32'h48);
        chk("single_hold", 32'(tx_data), 32'h48);

        // Hello burst, stall must never assert
        base = obs_q.size();
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(hello[i]);
            if (cpu_stall) early = 1'b1;
        end
        k = 0;
        while (obs_q.size() < base + 5 && k < 400) begin
            @(negedge clk);
            if (cpu_stall) early = 1'b1;
            k++;
        end
        tick(30);
        chk("hello_count", 32'(obs_q.size() - base), 5);
        for (int i = 0; i < 5; i++)
            if (obs_q.size() > base + i) chk($sformatf("hello_byte%0d", i), 32'(obs_q[base+i]), 32'(hello[i]));
        chk("hello_no_stall", 32'(early), 0);
        chk("hello_spacing", 32'(min_gap(base) >= 3), 1);

        // overfill while the UART is busy
        force_busy = 1'b1;
        tick(3);
        base = obs_q.size();
        for (int i = 1; i <= 10; i++) begin
            wr(8'h30 + 8'(i));
            if (i == 6) chk("overfill_stall_after6", 32'(cpu_stall), 0);
            if (i == 7) chk("overfill_stall_after7", 32'(cpu_stall), 1);
        end
        tick(1);
        chk("overfill_ovf", 32'(overflow_cnt), 2);
        chk("overfill_no_launch", 32'(obs_q.size() - base), 0);
        force_busy = 1'b0;
        wait_frames(base, 8, 600);
        chk("overfill_count", 32'(obs_q.size() - base), 8);
        for (int i = 0; i < 8; i++)
            if (obs_q.size() > base + i) chk($sformatf("overfill_byte%0d", i), 32'(obs_q[base+i]), 32'h31 + 32'(i));
        chk("overfill_stall_clear", 32'(cpu_stall), 0);

        // UART that never raises busy
        uart_silent = 1'b1;
        base = obs_q.size();
        wr(8'hA1);
        wr(8'hA2);
        wait_frames(base, 2, 200);
        chk("timeout_count", 32'(obs_q.size() - base), 2);
        if (obs_q.size() >= base + 2) begin
            chk("timeout_byte1", 32'(obs_q[base+1]), 32'hA2);
            chk("timeout_gap", 32'(start_q[base+1] - start_q[base]), BUSY_TIMEOUT + 1);
        end
        uart_silent = 1'b0;

        // drain after halt
        rise_dly = 2;
        hold_len = 4;
        base = obs_q.size();
        wr(8'h44);
        wr(8'h45);
        wr(8'h46);
        cpu_halt = 1'b1;
        falls = 0;
        early = 1'b0;
        prev_busy = tx_busy;
        k = 0;
        while (falls < 3 && k < 300) begin
            @(negedge clk);
            if (prev_busy && !tx_busy) falls++;
            else if (drained) early = 1'b1;
            prev_busy = tx_busy;
            k++;
        end
        chk("drain_falls", 32'(falls), 3);
        chk("drain_not_early", 32'(early | drained), 0);
        tick(2);
        chk("drain_high", 32'(drained), 1);
        wr(8'h47);
        chk("drain_drop_on_write", 32'(drained), 0);
        cpu_halt = 1'b0;
        wait_frames(base, 4, 200);
        chk("drain_count", 32'(obs_q.size() - base), 4);
        if (obs_q.size() >= base + 4) chk("drain_last", 32'(obs_q[base+3]), 32'h47);

        // async reset in the middle of a frame
        hold_len = 20;
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
        k = 0;
        while (!tx_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_start", 32'(tx_start), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_cpu_stall", 32'(cpu_stall), 0);
        chk("arst_drained", 32'(drained), 0);
        chk("arst_overflow", 32'(overflow_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = obs_q.size();
        tick(40);
        chk("arst_no_launch", 32'(obs_q.size() - base), 0);
        wr(8'h5A);
        wait_frames(base, 1, 200);
        chk("arst_new_count", 32'(obs_q.size() - base), 1);
        if (obs_q.size() > base) chk("arst_new_data", 32'(obs_q[base]), 32'h5A);

        // randomized traffic from a CPU that honours the stall
        base = obs_q.size();
        for (int blk = 0; blk < 3; blk++) begin
            rise_dly = $urandom_range(1, 3);
            hold_len = $urandom_range(1, 6);
            for (int i = 0; i < 20; i++) begin
                tick($urandom_range(0, 3));
                b = 8'($urandom);
                exp_q.push_back(b);
                wr_polite(b);
            end
        end
        wait_frames(base, 60, 4000);
        chk("rand_count", 32'(obs_q.size() - base), 60);
        for (int i = 0; i < 60; i++)
            if (obs_q.size() > base + i) chk($sformatf("rand_byte%0d", i), 32'(obs_q[base+i]), 32'(exp_q[i]));
        chk("rand_no_overflow", 32'(overflow_cnt), 0);
        chk("rand_spacing", 32'(min_gap(base) >= 3), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
